mem_arbiter: RTL and testbench

Single-port main-memory arbiter between the instruction-cache miss path and the data-cache controller. Accepts one read-fill or write-through request at a time, drives the shared memory handshake until `m_ready`, and returns a one-cycle ready pulse with line data to the winning requester. Sits between both cache controllers and the main-memory model, below the pipeline stall logic.

---
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port main-memory arbiter between I-cache fill and D-cache requests.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed data priority.
module mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [LINE_W-1:0] d_rdata,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              busy,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

    state_t            state_q;
    logic              owner_q, m_read_q, m_write_q, i_ready_q, d_ready_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
    logic              grant_d_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_q;
    // On a tie, data wins only if instruction was granted last.
    always_comb grant_d_d = d_req && (!i_req || !last_q);
`else
    always_comb grant_d_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q    <= 1'b0;
`endif
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            case (state_q)
                IDLE: if (i_req || d_req) begin
                    owner_q   <= grant_d_d;
                    m_addr_q  <= grant_d_d ? d_addr : i_addr;
                    m_wdata_q <= grant_d_d ? d_wdata : m_wdata_q;
                    m_read_q  <= !(grant_d_d && d_we);
                    m_write_q <= grant_d_d && d_we;
                    state_q   <= grant_d_d ? BUSY_D : BUSY_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_q    <= grant_d_d;
`endif
                end
                BUSY_I, BUSY_D: if (m_ready) begin
                    if (state_q == BUSY_D) begin
                        d_rdata_q <= m_rdata;
                        d_ready_q <= 1'b1;
                    end else begin
                        i_rdata_q <= m_rdata;
                        i_ready_q <= 1'b1;
                    end
                    m_read_q  <= 1'b0;
                    m_write_q <= 1'b0;
                    state_q   <= RELEASE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign m_read  = m_read_q;
    assign m_write = m_write_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign owner   = owner_q;
    assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter; expected ready pulses are queued and checked by a monitor.
module tb_mem_arbiter;
    logic         clk = 1'b0, rst = 1'b1;
    logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ready = 1'b0;
    logic [11:0]  i_addr = '0, d_addr = '0;
    logic [31:0]  d_wdata = '0;
    logic [127:0] m_rdata = '0;
    logic         i_ready, d_ready, m_read, m_write, busy, owner;
    logic [127:0] i_rdata, d_rdata;
    logic [11:0]  m_addr;
    logic [31:0]  m_wdata;

    typedef struct {
        logic         side;
        logic         chk;
        logic [127:0] data;
    } exp_t;
    exp_t sb[$];
    int   total = 0, passed = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    always @(negedge clk) begin
        if (i_ready || d_ready) begin
            chk("single_ready", {127'd0, i_ready && d_ready}, 128'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ready", {126'd0, i_ready, d_ready}, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ready_side", {127'd0, d_ready}, {127'd0, e.side});
                if (e.chk) chk("rdata", e.side ? d_rdata : i_rdata, e.data);
            end
        end
    end

    // Called before the grant edge; drives m_ready in the lat-th strobe cycle.
    task automatic serve(input logic own, input logic we, input logic [11:0] a,
                         input logic [31:0] wd, input int lat, input logic chg,
                         input logic [127:0] rd);
        exp_t e;
        @(posedge clk);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk("m_read", {127'd0, m_read}, {127'd0, !we});
            chk("m_write", {127'd0, m_write}, {127'd0, we});
            chk("m_addr", {116'd0, m_addr}, {116'd0, a});
            if (we) chk("m_wdata", {96'd0, m_wdata}, {96'd0, wd});
            chk("owner", {127'd0, owner}, {127'd0, own});
            chk("busy", {127'd0, busy}, 128'd1);
            if (chg) d_addr = 12'h3FF;
            if (c == lat) begin
                m_ready = 1'b1;
                m_rdata = rd;
                e.side = own;
                e.chk = !we;
                e.data = rd;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        if (own) d_req = 1'b0; else i_req = 1'b0;
        @(negedge clk);
        chk("release_strobes", {126'd0, m_read, m_write}, 128'd0);
        chk("release_busy", {127'd0, busy}, 128'd1);
        @(negedge clk);
        chk("idle_busy", {127'd0, busy}, 128'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_strobes", {126'd0, m_read, m_write}, 128'd0);
        chk("rst_owner", {127'd0, owner}, 128'd0);
        chk("rst_m_addr", {116'd0, m_addr}, 128'd0);
        chk("rst_m_wdata", {96'd0, m_wdata}, 128'd0);
        chk("rst_i_rdata", i_rdata, 128'd0);
        chk("rst_d_rdata", d_rdata, 128'd0);

        // I-read alone, m_ready in third strobe cycle
        i_req = 1'b1; i_addr = 12'h040;
        serve(1'b0, 1'b0, 12'h040, 32'd0, 3, 1'b0, 128'h0123_4567_89AB_CDEF_0000_1111_DEAD_BEEF);
        chk("i_rdata_hold", i_rdata, 128'h0123_4567_89AB_CDEF_0000_1111_DEAD_BEEF);

        // Tie: data first; second tie depends on arbitration mode
        i_req = 1'b1; i_addr = 12'h100;
        d_req = 1'b1; d_addr = 12'h200; d_we = 1'b0;
        serve(1'b1, 1'b0, 12'h200, 32'd0, 2, 1'b0, 128'hAAAA_0000_0000_0000_0000_0000_0000_0200);
        d_req = 1'b1; d_addr = 12'h208;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        serve(1'b0, 1'b0, 12'h100, 32'd0, 1, 1'b0, 128'h1111_0000_0000_0000_0000_0000_0000_0100);
        serve(1'b1, 1'b0, 12'h208, 32'd0, 1, 1'b0, 128'hBBBB_0000_0000_0000_0000_0000_0000_0208);
`else
        serve(1'b1, 1'b0, 12'h208, 32'd0, 1, 1'b0, 128'hBBBB_0000_0000_0000_0000_0000_0000_0208);
        serve(1'b0, 1'b0, 12'h100, 32'd0, 1, 1'b0, 128'h1111_0000_0000_0000_0000_0000_0000_0100);
`endif

        // D-write with minimum turnaround
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h010; d_wdata = 32'h1234_5678;
        serve(1'b1, 1'b1, 12'h010, 32'h1234_5678, 1, 1'b0, 128'h0);
        d_we = 1'b0;

        // Operand stability: d_addr changes while BUSY_D
        d_req = 1'b1; d_addr = 12'h010;
        serve(1'b1, 1'b0, 12'h010, 32'd0, 3, 1'b1, 128'hCAFE_F00D_0000_0000_0000_0000_0000_0010);
        chk("d_rdata_hold", d_rdata, 128'hCAFE_F00D_0000_0000_0000_0000_0000_0010);

        // Stray m_ready in IDLE
        m_ready = 1'b1; m_rdata = 128'h5555;
        repeat (2) begin
            @(negedge clk);
            chk("stray_busy", {127'd0, busy}, 128'd0);
            chk("stray_strobes", {126'd0, m_read, m_write}, 128'd0);
        end
        m_ready = 1'b0;

        // Reset mid-BUSY, then late m_ready
        i_req = 1'b1; i_addr = 12'h0AA;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_m_read", {127'd0, m_read}, 128'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; i_req = 1'b0; m_ready = 1'b1; m_rdata = 128'h7777;
        @(negedge clk);
        chk("mid_rst_strobes", {126'd0, m_read, m_write}, 128'd0);
        chk("mid_rst_busy", {127'd0, busy}, 128'd0);
        chk("mid_rst_i_rdata", i_rdata, 128'd0);
        @(negedge clk);
        chk("late_mready_busy", {127'd0, busy}, 128'd0);
        chk("late_mready_strobes", {126'd0, m_read, m_write}, 128'd0);
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_empty", {96'd0, 32'(sb.size())}, 128'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
